// File: rtl/pipeline_sequencer.sv
// Central stall/flush controller for the five-stage pipeline: per-stage stall/invalidate,
// fetch PC-source select, redirect recovery / WFI sleep FSM and two performance counters.
module pipeline_sequencer #(
    parameter int STALL_COUNT_WIDTH    = 32,
    parameter int REDIRECT_COUNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [4:0]                      rs1_addr_dec,
    input  logic [4:0]                      rs2_addr_dec,
    input  logic                            uses_rs1_dec,
    input  logic                            uses_rs2_dec,
    input  logic                            csr_read_dec,
    input  logic [4:0]                      rd_addr_ex,
    input  logic                            load_ex,
    input  logic                            csr_hazard_ex,
    input  logic                            branch_taken_mem,
    input  logic                            mem_busy,
    input  logic                            fetch_busy,
    input  logic                            trap_wb,
    input  logic                            mret_wb,
    input  logic                            wfi_wb,
    input  logic                            interrupt_pending,
    output logic                            stall_fetch,
    output logic                            stall_decode,
    output logic                            stall_execute,
    output logic                            stall_memory,
    output logic                            invalidate_fetch,
    output logic                            invalidate_decode,
    output logic                            invalidate_execute,
    output logic                            invalidate_memory,
    output logic [1:0]                      pc_select,
    output logic                            sleeping,
    output logic [STALL_COUNT_WIDTH-1:0]    stall_count,
    output logic [REDIRECT_COUNT_WIDTH-1:0] redirect_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_WFI      = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_TRAP   = 2'd2;
    localparam logic [1:0] PC_MEPC   = 2'd3;

    localparam logic [STALL_COUNT_WIDTH-1:0]    STALL_ONE    = {{(STALL_COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REDIRECT_COUNT_WIDTH-1:0] REDIRECT_ONE = {{(REDIRECT_COUNT_WIDTH-1){1'b0}}, 1'b1};

    // Vector bit order: [3]=fetch, [2]=decode, [1]=execute, [0]=memory
    localparam logic [3:0] SEL_NONE    = 4'b0000;
    localparam logic [3:0] SEL_ALL     = 4'b1111;
    localparam logic [3:0] SEL_FETCH   = 4'b1000;
    localparam logic [3:0] SEL_DECODE  = 4'b0100;
    localparam logic [3:0] SEL_MEMORY  = 4'b0001;
    localparam logic [3:0] SEL_FRONT2  = 4'b1100;
    localparam logic [3:0] SEL_FRONT3  = 4'b1110;

    state_t                          state_reg;
    state_t                          state_next;
    logic                            sleeping_reg;
    logic [STALL_COUNT_WIDTH-1:0]    stall_count_reg;
    logic [REDIRECT_COUNT_WIDTH-1:0] redirect_count_reg;

    logic [3:0] stall_vec;
    logic [3:0] inv_vec;
    logic [1:0] pc_sel;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic [4:0] src_addr [2];
    logic [1:0] src_used;
    logic [1:0] src_match;
    logic       load_use_hazard;
    logic       csr_hazard;

    assign src_addr[0] = rs1_addr_dec;
    assign src_addr[1] = rs2_addr_dec;
    assign src_used    = {uses_rs2_dec, uses_rs1_dec};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src_match
            assign src_match[gi] = src_used[gi] && (src_addr[gi] == rd_addr_ex);
        end
    endgenerate

    // x0 is never a real producer, so a zero destination cannot cause a load-use stall
    assign load_use_hazard = load_ex && (rd_addr_ex != 5'd0) && (|src_match);
    assign csr_hazard      = csr_hazard_ex && csr_read_dec;

    // ------------------------------------------------------------------
    // Next-state and stage-control decode, strict priority order
    // ------------------------------------------------------------------
    always_comb begin
        stall_vec  = SEL_NONE;
        inv_vec    = SEL_NONE;
        pc_sel     = PC_SEQ;
        state_next = state_reg;

        if (reset) begin
            inv_vec    = SEL_ALL;
            state_next = ST_RUN;
        end else if (trap_wb || mret_wb) begin
            inv_vec    = SEL_ALL;
            pc_sel     = trap_wb ? PC_TRAP : PC_MEPC;
            state_next = ST_REDIRECT;
        end else if (state_reg == ST_WFI) begin
            stall_vec = SEL_FETCH;
            inv_vec   = SEL_ALL;
            if (interrupt_pending) begin
                state_next = ST_RUN;
            end
        end else if ((state_reg == ST_RUN) && wfi_wb && !interrupt_pending) begin
            stall_vec  = SEL_FETCH;
            inv_vec    = SEL_ALL;
            state_next = ST_WFI;
        end else if ((state_reg == ST_RUN) && branch_taken_mem) begin
            pc_sel     = PC_BRANCH;
            inv_vec    = SEL_FRONT3;
            state_next = ST_REDIRECT;
        end else begin
            if (mem_busy) begin
                stall_vec = SEL_ALL;
                inv_vec   = SEL_MEMORY;
            end else if (load_use_hazard || csr_hazard) begin
                stall_vec = SEL_FRONT2;
                inv_vec   = SEL_DECODE;
            end else if (fetch_busy) begin
                inv_vec = SEL_FETCH;
            end

            // The recovery cycle squashes the wrong-path fetch still in flight;
            // an unexpected encoding is also steered back to RUN here.
            if (state_reg == ST_REDIRECT) begin
                inv_vec[3] = 1'b1;
            end
            if (state_reg != ST_RUN) begin
                state_next = ST_RUN;
            end
        end
    end

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= ST_RUN;
            sleeping_reg       <= 1'b0;
            stall_count_reg    <= '0;
            redirect_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            sleeping_reg <= (state_next == ST_WFI);
            if (stall_vec[2] && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + STALL_ONE;
            end
            if (pc_sel != PC_SEQ) begin
                redirect_count_reg <= redirect_count_reg + REDIRECT_ONE;
            end
        end
    end

    assign stall_fetch        = stall_vec[3];
    assign stall_decode       = stall_vec[2];
    assign stall_execute      = stall_vec[1];
    assign stall_memory       = stall_vec[0];
    assign invalidate_fetch   = inv_vec[3];
    assign invalidate_decode  = inv_vec[2];
    assign invalidate_execute = inv_vec[1];
    assign invalidate_memory  = inv_vec[0];
    assign pc_select          = pc_sel;
    assign sleeping           = sleeping_reg;
    assign stall_count        = stall_count_reg;
    assign redirect_count     = redirect_count_reg;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus randomized
// traffic compared against a priority-rule reference model.
module tb_pipeline_sequencer;

    localparam int SW = 4;
    localparam int RW = 4;
    localparam int M_RUN = 0;
    localparam int M_REDIRECT = 1;
    localparam int M_WFI = 2;
    localparam logic [SW-1:0] SMAX = '1;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] rs1_addr_dec, rs2_addr_dec, rd_addr_ex;
    logic uses_rs1_dec, uses_rs2_dec, csr_read_dec, load_ex, csr_hazard_ex;
    logic branch_taken_mem, mem_busy, fetch_busy, trap_wb, mret_wb, wfi_wb, interrupt_pending;
    logic stall_fetch, stall_decode, stall_execute, stall_memory;
    logic invalidate_fetch, invalidate_decode, invalidate_execute, invalidate_memory;
    logic [1:0] pc_select;
    logic sleeping;
    logic [SW-1:0] stall_count;
    logic [RW-1:0] redirect_count;

    int checks = 0;
    int failures = 0;

    int m_state;
    logic [SW-1:0] m_stall;
    logic [RW-1:0] m_redir;

    pipeline_sequencer #(
        .STALL_COUNT_WIDTH(SW),
        .REDIRECT_COUNT_WIDTH(RW)
    ) dut (
        .clk(clk), .reset(reset),
        .rs1_addr_dec(rs1_addr_dec), .rs2_addr_dec(rs2_addr_dec),
        .uses_rs1_dec(uses_rs1_dec), .uses_rs2_dec(uses_rs2_dec),
        .csr_read_dec(csr_read_dec), .rd_addr_ex(rd_addr_ex),
        .load_ex(load_ex), .csr_hazard_ex(csr_hazard_ex),
        .branch_taken_mem(branch_taken_mem), .mem_busy(mem_busy), .fetch_busy(fetch_busy),
        .trap_wb(trap_wb), .mret_wb(mret_wb), .wfi_wb(wfi_wb),
        .interrupt_pending(interrupt_pending),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .stall_execute(stall_execute), .stall_memory(stall_memory),
        .invalidate_fetch(invalidate_fetch), .invalidate_decode(invalidate_decode),
        .invalidate_execute(invalidate_execute), .invalidate_memory(invalidate_memory),
        .pc_select(pc_select), .sleeping(sleeping),
        .stall_count(stall_count), .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    // {stall f,d,e,m, invalidate f,d,e,m, pc_select}
    function automatic logic [9:0] obs();
        return {stall_fetch, stall_decode, stall_execute, stall_memory,
                invalidate_fetch, invalidate_decode, invalidate_execute, invalidate_memory,
                pc_select};
    endfunction

    // Reference: the event list applied top-down, first active event wins
    function automatic logic [9:0] model_out();
        logic [3:0] st;
        logic [3:0] inv;
        logic [1:0] pc;
        logic hz;
        st = 4'b0; inv = 4'b0; pc = 2'd0;
        hz = (load_ex && rd_addr_ex != 0 &&
              ((uses_rs1_dec && rs1_addr_dec == rd_addr_ex) ||
               (uses_rs2_dec && rs2_addr_dec == rd_addr_ex))) ||
             (csr_hazard_ex && csr_read_dec);
        if (reset) inv = 4'b1111;
        else if (trap_wb) begin inv = 4'b1111; pc = 2'd2; end
        else if (mret_wb) begin inv = 4'b1111; pc = 2'd3; end
        else if (m_state == M_WFI) begin st = 4'b1000; inv = 4'b1111; end
        else if (m_state == M_RUN && wfi_wb && !interrupt_pending) begin st = 4'b1000; inv = 4'b1111; end
        else if (m_state == M_RUN && branch_taken_mem) begin inv = 4'b1110; pc = 2'd1; end
        else if (mem_busy) begin st = 4'b1111; inv = 4'b0001; end
        else if (hz) begin st = 4'b1100; inv = 4'b0100; end
        else if (fetch_busy) inv = 4'b1000;
        if (!reset && m_state == M_REDIRECT) inv[3] = 1'b1;
        return {st, inv, pc};
    endfunction

    // Advance one clock, updating the reference state from the inputs held this cycle
    task automatic tick();
        logic [9:0] e;
        int ns;
        logic [SW-1:0] nsc;
        logic [RW-1:0] nrc;
        e = model_out();
        ns = m_state; nsc = m_stall; nrc = m_redir;
        if (reset) begin
            ns = M_RUN; nsc = '0; nrc = '0;
        end else begin
            if (e[8] && m_stall != SMAX) nsc = m_stall + 1'b1;
            if (e[1:0] != 2'd0) nrc = m_redir + 1'b1;
            if (trap_wb || mret_wb) ns = M_REDIRECT;
            else if (m_state == M_WFI) ns = interrupt_pending ? M_RUN : M_WFI;
            else if (m_state == M_RUN && wfi_wb && !interrupt_pending) ns = M_WFI;
            else if (m_state == M_RUN && branch_taken_mem) ns = M_REDIRECT;
            else ns = M_RUN;
        end
        @(posedge clk);
        #1;
        m_state = ns; m_stall = nsc; m_redir = nrc;
    endtask

    task automatic clear_inputs();
        rs1_addr_dec = 0; rs2_addr_dec = 0; rd_addr_ex = 0;
        uses_rs1_dec = 0; uses_rs2_dec = 0; csr_read_dec = 0;
        load_ex = 0; csr_hazard_ex = 0; branch_taken_mem = 0;
        mem_busy = 0; fetch_busy = 0; trap_wb = 0; mret_wb = 0;
        wfi_wb = 0; interrupt_pending = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        #1;
        checks++;
        if (obs() !== 10'b0000_1111_00) begin
            failures++; $display("FAIL reset_outputs got=%b exp=%b", obs(), 10'b0000_1111_00);
        end
        tick();
        tick();
        checks++;
        if ({sleeping, stall_count, redirect_count} !== {1'b0, {SW{1'b0}}, {RW{1'b0}}}) begin
            failures++; $display("FAIL reset_state got sleep=%b sc=%0d rc=%0d exp 0/0/0",
                                 sleeping, stall_count, redirect_count);
        end
        reset = 0;
        #1;
        checks++;
        if (obs() !== 10'b0) begin
            failures++; $display("FAIL idle_after_reset got=%b exp=%b", obs(), 10'b0);
        end
        $display("txn reset done");
    endtask

    task automatic test_load_use();
        clear_inputs();
        load_ex = 1; rd_addr_ex = 5; rs2_addr_dec = 5; uses_rs2_dec = 1;
        #1;
        checks++;
        if (obs() !== 10'b1100_0100_00) begin
            failures++; $display("FAIL load_use got=%b exp=%b", obs(), 10'b1100_0100_00);
        end
        tick();
        checks++;
        if (stall_count !== 4'd1) begin
            failures++; $display("FAIL load_use_count got=%0d exp=1", stall_count);
        end
        rd_addr_ex = 0; rs2_addr_dec = 0;
        #1;
        checks++;
        if (obs() !== 10'b0) begin
            failures++; $display("FAIL load_use_x0 got=%b exp=%b", obs(), 10'b0);
        end
        tick();
        clear_inputs();
        csr_hazard_ex = 1; csr_read_dec = 1;
        #1;
        checks++;
        if (obs() !== 10'b1100_0100_00) begin
            failures++; $display("FAIL csr_hazard got=%b exp=%b", obs(), 10'b1100_0100_00);
        end
        tick();
        checks++;
        if (stall_count !== 4'd2) begin
            failures++; $display("FAIL csr_hazard_count got=%0d exp=2", stall_count);
        end
        clear_inputs();
        $display("txn load_use done sc=%0d", stall_count);
    endtask

    task automatic test_branch();
        clear_inputs();
        branch_taken_mem = 1;
        #1;
        checks++;
        if (obs() !== 10'b0000_1110_01) begin
            failures++; $display("FAIL branch_issue got=%b exp=%b", obs(), 10'b0000_1110_01);
        end
        tick();
        branch_taken_mem = 0;
        #1;
        checks++;
        if (obs() !== 10'b0000_1000_00) begin
            failures++; $display("FAIL branch_recover got=%b exp=%b", obs(), 10'b0000_1000_00);
        end
        tick();
        checks++;
        if (obs() !== 10'b0 || redirect_count !== 4'd1) begin
            failures++; $display("FAIL branch_done got=%b rc=%0d exp=%b rc=1", obs(), redirect_count, 10'b0);
        end
        $display("txn branch done rc=%0d", redirect_count);
    endtask

    task automatic test_priority();
        clear_inputs();
        trap_wb = 1; mret_wb = 1; branch_taken_mem = 1; mem_busy = 1;
        #1;
        checks++;
        if (obs() !== 10'b0000_1111_10) begin
            failures++; $display("FAIL trap_priority got=%b exp=%b", obs(), 10'b0000_1111_10);
        end
        tick();
        clear_inputs();
        mret_wb = 1;
        #1;
        checks++;
        if (obs() !== 10'b0000_1111_11) begin
            failures++; $display("FAIL mret_in_redirect got=%b exp=%b", obs(), 10'b0000_1111_11);
        end
        tick();
        clear_inputs();
        mem_busy = 1;
        #1;
        checks++;
        if (obs() !== 10'b1111_1001_00) begin
            failures++; $display("FAIL redirect_mem_busy got=%b exp=%b", obs(), 10'b1111_1001_00);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (obs() !== 10'b0 || redirect_count !== m_redir) begin
            failures++; $display("FAIL priority_done got=%b rc=%0d exp=%b rc=%0d", obs(), redirect_count, 10'b0, m_redir);
        end
        $display("txn priority done rc=%0d", redirect_count);
    endtask

    task automatic test_wfi();
        clear_inputs();
        wfi_wb = 1;
        #1;
        checks++;
        if (obs() !== 10'b1000_1111_00) begin
            failures++; $display("FAIL wfi_enter got=%b exp=%b", obs(), 10'b1000_1111_00);
        end
        tick();
        wfi_wb = 0;
        checks++;
        if (sleeping !== 1'b1) begin
            failures++; $display("FAIL wfi_sleeping got=%b exp=1", sleeping);
        end
        for (int i = 0; i < 10; i++) begin
            fetch_busy = 1'($urandom_range(0, 1));
            mem_busy = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (obs() !== 10'b1000_1111_00 || sleeping !== 1'b1) begin
                failures++; $display("FAIL wfi_hold cyc=%0d got=%b sleep=%b exp=%b sleep=1",
                                     i, obs(), sleeping, 10'b1000_1111_00);
            end
            tick();
        end
        clear_inputs();
        interrupt_pending = 1;
        #1;
        checks++;
        if (obs() !== 10'b1000_1111_00) begin
            failures++; $display("FAIL wfi_wake_cycle got=%b exp=%b", obs(), 10'b1000_1111_00);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (sleeping !== 1'b0 || obs() !== 10'b0) begin
            failures++; $display("FAIL wfi_exit got sleep=%b out=%b exp sleep=0 out=%b", sleeping, obs(), 10'b0);
        end
        $display("txn wfi done");
    endtask

    task automatic test_mem_busy_hazard();
        clear_inputs();
        load_ex = 1; rd_addr_ex = 7; rs1_addr_dec = 7; uses_rs1_dec = 1; mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs() !== 10'b1111_0001_00) begin
                failures++; $display("FAIL mem_busy cyc=%0d got=%b exp=%b", i, obs(), 10'b1111_0001_00);
            end
            tick();
        end
        mem_busy = 0;
        #1;
        checks++;
        if (obs() !== 10'b1100_0100_00) begin
            failures++; $display("FAIL mem_busy_release got=%b exp=%b", obs(), 10'b1100_0100_00);
        end
        tick();
        clear_inputs();
        $display("txn mem_busy done sc=%0d", stall_count);
    endtask

    task automatic test_saturation();
        clear_inputs();
        mem_busy = 1;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (stall_count !== 4'hF) begin
            failures++; $display("FAIL stall_saturate got=%0d exp=15", stall_count);
        end
        clear_inputs();
        $display("txn saturation done sc=%0d", stall_count);
    endtask

    task automatic test_reset_in_wfi();
        clear_inputs();
        wfi_wb = 1;
        tick();
        wfi_wb = 0;
        checks++;
        if (sleeping !== 1'b1) begin
            failures++; $display("FAIL wfi_before_reset got=%b exp=1", sleeping);
        end
        reset = 1;
        #1;
        checks++;
        if (obs() !== 10'b0000_1111_00) begin
            failures++; $display("FAIL reset_in_wfi_out got=%b exp=%b", obs(), 10'b0000_1111_00);
        end
        tick();
        reset = 0;
        #1;
        checks++;
        if ({sleeping, stall_count, redirect_count} !== {1'b0, {SW{1'b0}}, {RW{1'b0}}} || obs() !== 10'b0) begin
            failures++; $display("FAIL reset_in_wfi got sleep=%b sc=%0d rc=%0d out=%b exp 0/0/0 out=0",
                                 sleeping, stall_count, redirect_count, obs());
        end
        $display("txn reset_in_wfi done");
    endtask

    task automatic test_random();
        logic [9:0] e;
        for (int n = 0; n < 400; n++) begin
            trap_wb           = ($urandom_range(0, 99) < 3);
            mret_wb           = ($urandom_range(0, 99) < 3);
            wfi_wb            = ($urandom_range(0, 99) < 5);
            interrupt_pending = ($urandom_range(0, 99) < 25);
            branch_taken_mem  = ($urandom_range(0, 99) < 15);
            mem_busy          = ($urandom_range(0, 99) < 20);
            fetch_busy        = ($urandom_range(0, 99) < 25);
            load_ex           = ($urandom_range(0, 99) < 40);
            csr_hazard_ex     = ($urandom_range(0, 99) < 10);
            csr_read_dec      = ($urandom_range(0, 99) < 30);
            uses_rs1_dec      = 1'($urandom_range(0, 1));
            uses_rs2_dec      = 1'($urandom_range(0, 1));
            rd_addr_ex        = 5'($urandom_range(0, 3));
            rs1_addr_dec      = 5'($urandom_range(0, 3));
            rs2_addr_dec      = 5'($urandom_range(0, 3));
            reset             = ($urandom_range(0, 99) < 2);
            #1;
            e = model_out();
            checks++;
            if (obs() !== e) begin
                failures++; $display("FAIL rand_out n=%0d got=%b exp=%b", n, obs(), e);
            end
            tick();
            checks++;
            if (sleeping !== (m_state == M_WFI) || stall_count !== m_stall || redirect_count !== m_redir) begin
                failures++; $display("FAIL rand_state n=%0d got sleep=%b sc=%0d rc=%0d exp sleep=%b sc=%0d rc=%0d",
                                     n, sleeping, stall_count, redirect_count, (m_state == M_WFI), m_stall, m_redir);
            end
            $display("txn rand %0d out=%b sc=%0d rc=%0d sleep=%b", n, e, stall_count, redirect_count, sleeping);
        end
        reset = 0;
        clear_inputs();
    endtask

    initial begin
        m_state = M_RUN; m_stall = '0; m_redir = '0;
        test_reset();
        test_load_use();
        test_branch();
        test_priority();
        test_wfi();
        test_mem_busy_hazard();
        test_saturation();
        test_reset_in_wfi();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
